// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared defaults and id-width helper for the ROM read arbiter
package rom_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_ADDR_W  = 5;
  localparam int DEFAULT_DATA_W  = 4;

  // Bits needed to encode n distinct ids; never less than one bit
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >>> 1) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  localparam int ID_W = clog2(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant plus encoded id
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int GNT_ID_W = ID_W
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [GNT_ID_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [GNT_ID_W-1:0] o_grant_id,
  output logic                o_any
);

  int   w_idx;
  logic w_found;

  // Scan requests starting at the pointer, wrapping; the first set bit wins
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_id     = GNT_ID_W'(w_idx);
        w_found        = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin sharing of one synchronous ROM among several requesters
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      rom_rden,
  input  logic [DATA_W-1:0]         rom_q
);

  localparam int REQ_ID_W = clog2(NUM_REQ);

  logic [REQ_ID_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]     r_last_addr;
  logic [RD_LATENCY-1:0] r_pipe_valid;
  logic [REQ_ID_W-1:0]   r_pipe_id [RD_LATENCY];

  logic [NUM_REQ-1:0]    w_grant;
  logic [REQ_ID_W-1:0]   w_grant_id;
  logic                  w_any;
  logic                  w_hs;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [REQ_ID_W-1:0]   w_next_ptr;
  logic                  w_rsp_live;
  logic [REQ_ID_W-1:0]   w_rsp_id;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .GNT_ID_W (REQ_ID_W)
  ) u_rr_arbiter (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  // The grant is suppressed while reset is held so nothing is issued during reset
  assign w_hs       = reset_n & w_any;
  assign req_ready  = w_grant & {NUM_REQ{reset_n}};
  assign w_win_addr = req_addr[w_grant_id*ADDR_W +: ADDR_W];
  assign w_next_ptr = (w_grant_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_id + 1'b1);

  // Winner's address goes straight to the ROM; when idle the last address is held to avoid toggling
  assign rom_rden    = w_hs;
  assign rom_address = w_hs ? w_win_addr : r_last_addr;

  // Pointer moves past the winner on each handshake; last-address register follows the issued read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_last_addr <= '0;
    end else if (w_hs) begin
      r_ptr       <= w_next_ptr;
      r_last_addr <= w_win_addr;
    end
  end

  // Shift {valid, id} alongside the ROM's own latency so the tag lines up with rom_q
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_valid <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_pipe_id[k] <= '0;
      end
    end else begin
      r_pipe_valid[0] <= w_hs;
      r_pipe_id[0]    <= w_grant_id;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_pipe_valid[k] <= r_pipe_valid[k-1];
        r_pipe_id[k]    <= r_pipe_id[k-1];
      end
    end
  end

  assign w_rsp_live = r_pipe_valid[RD_LATENCY-1];
  assign w_rsp_id   = r_pipe_id[RD_LATENCY-1];

  // Route the returning tag to a one-hot valid; data comes from the ROM output unregistered
  always_comb begin
    rsp_valid = '0;
    if (w_rsp_live) begin
      rsp_valid[w_rsp_id] = 1'b1;
    end
  end

  assign rsp_data = w_rsp_live ? rom_q : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - directed self-checking bench for rom_read_arbiter
module tb_rom_read_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_data;
  logic [4:0]  rom_address;
  logic        rom_rden;
  logic [3:0]  rom_q;

  logic [4:0]  rom_a_reg = '0;

  int errors = 0;
  int checks = 0;

  rom_read_arbiter #(
    .NUM_REQ    (4),
    .ADDR_W     (5),
    .DATA_W     (4),
    .RD_LATENCY (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rom_address (rom_address),
    .rom_rden    (rom_rden),
    .rom_q       (rom_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM with registered address and registered q: mem[a] = a[3:0], two-cycle latency
  initial rom_q = '0;
  always @(posedge clock) begin
    if (rom_rden) rom_a_reg <= rom_address;
    rom_q <= rom_a_reg[3:0];
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom);
      req_addr  = 20'($urandom);
      @(negedge clock);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready c%0d: got %b expected 0000", c, req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid c%0d: got %b expected 0000", c, rsp_valid); end
      checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL reset_rsp_data c%0d: got %h expected 0", c, rsp_data); end
      checks++; if (rom_rden !== 1'b0) begin errors++; $display("FAIL reset_rden c%0d: got %b expected 0", c, rom_rden); end
      checks++; if (rom_address !== 5'd0) begin errors++; $display("FAIL reset_addr c%0d: got %0d expected 0", c, rom_address); end
      step();
    end
    reset_n   = 1'b1;
    req_valid = 4'b0011;
    req_addr  = '0;
    req_addr[0 +: 5] = 5'd9;
    req_addr[5 +: 5] = 5'd4;
    @(negedge clock);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
    checks++; if (rom_address !== 5'd9) begin errors++; $display("FAIL first_addr: got %0d expected 9", rom_address); end
    checks++; if (rom_rden !== 1'b1) begin errors++; $display("FAIL first_rden: got %b expected 1", rom_rden); end
    step();
    req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (rom_rden !== 1'b0) begin errors++; $display("FAIL first_idle_rden: got %b expected 0", rom_rden); end
    checks++; if (rom_address !== 5'd9) begin errors++; $display("FAIL first_idle_addr: got %0d expected 9", rom_address); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL first_early_rsp: got %b expected 0000", rsp_valid); end
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL first_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 4'h9) begin errors++; $display("FAIL first_rsp_data: got %h expected 9", rsp_data); end
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL first_rsp_after: got %b expected 0000", rsp_valid); end
    step();
  endtask

  // Pointer is 1 here; requester 2 is the first set bit from 1
  task automatic test_single_read;
    req_valid = 4'b0100;
    req_addr[10 +: 5] = 5'd3;
    @(negedge clock);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    checks++; if (rom_address !== 5'd3) begin errors++; $display("FAIL single_addr: got %0d expected 3", rom_address); end
    checks++; if (rom_rden !== 1'b1) begin errors++; $display("FAIL single_rden: got %b expected 1", rom_rden); end
    step();
    req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid); end
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_data !== 4'h3) begin errors++; $display("FAIL single_rsp_data: got %h expected 3", rsp_data); end
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_after: got %b expected 0000", rsp_valid); end
    step();
  endtask

  // Pointer is 3 after granting requester 2
  task automatic test_pointer_fairness;
    logic [3:0] tbl [3];
    logic [3:0] exp_rsp;
    tbl[0] = 4'b1000;
    tbl[1] = 4'b0001;
    tbl[2] = 4'b1000;
    req_addr[0  +: 5] = 5'd16;
    req_addr[15 +: 5] = 5'd27;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 3) ? 4'b1001 : 4'b0000;
      @(negedge clock);
      checks++;
      if (req_ready !== ((c < 3) ? tbl[c] : 4'b0000)) begin
        errors++; $display("FAIL fair_ready c%0d: got %b expected %b", c, req_ready, (c < 3) ? tbl[c] : 4'b0000);
      end
      exp_rsp = (c >= 2 && c < 5) ? tbl[c-2] : 4'b0000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL fair_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 4'b0000) begin
        checks++;
        if (rsp_data !== ((exp_rsp == 4'b1000) ? 4'hB : 4'h0)) begin
          errors++; $display("FAIL fair_rsp_data c%0d: got %h expected %h", c, rsp_data, (exp_rsp == 4'b1000) ? 4'hB : 4'h0);
        end
      end
      step();
    end
  endtask

  // Pointer is 0 here
  task automatic test_round_robin;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'(i);
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      exp_ready = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      exp_rsp   = (c >= 2 && c < 10) ? 4'(1 << ((c - 2) % 4)) : 4'b0000;
      @(negedge clock);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c%0d: got %b expected %b", c, req_ready, exp_ready); end
      if (c < 8) begin
        checks++; if (rom_address !== 5'(c % 4)) begin errors++; $display("FAIL rr_addr c%0d: got %0d expected %0d", c, rom_address, c % 4); end
      end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 4'b0000) begin
        checks++; if (rsp_data !== 4'((c - 2) % 4)) begin errors++; $display("FAIL rr_rsp_data c%0d: got %h expected %0d", c, rsp_data, (c - 2) % 4); end
      end
      step();
    end
  endtask

  // Pointer is 0; a lone requester 1 must be served every cycle
  task automatic test_single_continuous;
    req_addr[5 +: 5] = 5'd5;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4) ? 4'b0010 : 4'b0000;
      @(negedge clock);
      checks++;
      if (req_ready !== ((c < 4) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL cont_ready c%0d: got %b expected %b", c, req_ready, (c < 4) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (rsp_valid !== ((c >= 2 && c < 6) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL cont_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c >= 2 && c < 6) ? 4'b0010 : 4'b0000);
      end
      if (c >= 2 && c < 6) begin
        checks++; if (rsp_data !== 4'h5) begin errors++; $display("FAIL cont_rsp_data c%0d: got %h expected 5", c, rsp_data); end
      end
      step();
    end
  endtask

  // Pointer is 2; request at the pointer index is granted immediately
  task automatic test_idle_hold;
    req_addr[10 +: 5] = 5'd31;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      if (c == 0) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL idle_grant: got %b expected 0100", req_ready); end
      end
      checks++; if (rom_address !== 5'd31) begin errors++; $display("FAIL idle_addr c%0d: got %0d expected 31", c, rom_address); end
      checks++; if (rom_rden !== (c == 0)) begin errors++; $display("FAIL idle_rden c%0d: got %b expected %b", c, rom_rden, c == 0); end
      checks++;
      if (rsp_valid !== ((c == 2) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL idle_rsp_valid c%0d: got %b expected %b", c, rsp_valid, (c == 2) ? 4'b0100 : 4'b0000);
      end
      if (c == 2) begin
        checks++; if (rsp_data !== 4'hF) begin errors++; $display("FAIL idle_rsp_data: got %h expected f", rsp_data); end
      end
      step();
    end
  endtask

  // Pointer is 3; grant requester 1 (pointer would become 2), then reset in flight
  task automatic test_reset_midflight;
    req_addr[0  +: 5] = 5'd12;
    req_addr[5  +: 5] = 5'd7;
    req_addr[10 +: 5] = 5'd20;
    req_valid = 4'b0010;
    @(negedge clock);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b expected 0010", req_ready); end
    step();
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_in_reset: got %b expected 0000", rsp_valid); end
    checks++; if (rom_address !== 5'd0) begin errors++; $display("FAIL mid_addr_in_reset: got %0d expected 0", rom_address); end
    step();
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_after_reset: got %b expected 0000", rsp_valid); end
    step();
    req_valid = 4'b0101;
    @(negedge clock);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_cleared: got %b expected 0001", req_ready); end
    checks++; if (rom_address !== 5'd12) begin errors++; $display("FAIL mid_addr: got %0d expected 12", rom_address); end
    step();
    req_valid = 4'b0000;
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 4'hC) begin errors++; $display("FAIL mid_rsp_data: got %h expected c", rsp_data); end
    step();
    @(negedge clock);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_after: got %b expected 0000", rsp_valid); end
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single_read();
    test_pointer_fairness();
    test_round_robin();
    test_single_continuous();
    test_idle_hold();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
